// File: rtl/coin_collect_controller.sv
// Coin-collection initiator: turns Pac-Man/coin pixel overlap into a one-cycle
// tile-clear pulse and keeps the coins-left counter, BCD score and level state.
module coin_collect_controller #(
  parameter int unsigned TOTAL_COINS     = 233,
  parameter logic [7:0]  COIN_POINTS_BCD = 8'h10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        newGame,
  input  logic        drawingRequestPacman,
  input  logic        drawingRequestCoin,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  output logic        collision_pc,
  output logic [15:0] score,
  output logic [8:0]  coinsLeft,
  output logic        levelDone
);

  localparam int unsigned TABLE_SIZE = 4;
  localparam logic [8:0]  COINS_INIT = 9'(TOTAL_COINS);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    CLEARED
  } state_t;

  state_t      state_reg, state_next;
  logic        pulse_reg, pulse_next;
  logic [15:0] score_reg, score_next;
  logic [8:0]  coins_reg, coins_next;
  logic        done_reg, done_next;

  logic [TABLE_SIZE-1:0] valid_reg, valid_next, valid_eff, match_vec;
  logic [3:0]            row_reg [TABLE_SIZE];
  logic [4:0]            col_reg [TABLE_SIZE];

  logic [3:0] hit_row;
  logic [4:0] hit_col;
  logic       raw_hit;
  logic       tile_known;
  logic       table_full;
  logic       counted;
  logic [1:0] free_idx;
  logic       unused_bits;

  assign hit_row     = offsetY[8:5];
  assign hit_col     = offsetX[9:5];
  assign unused_bits = ^{offsetX[10], offsetY[10:9]};

  // Local X 31 is masked so the one-cycle-late clear never lands in the next tile.
  assign raw_hit = drawingRequestPacman & drawingRequestCoin & (offsetX[4:0] != 5'd31);

  // A start-of-frame edge empties the table before the same-cycle hit is looked up.
  assign valid_eff = startOfFrame ? '0 : valid_reg;

  generate
    for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_match
      assign match_vec[gi] = valid_eff[gi] && (row_reg[gi] == hit_row) && (col_reg[gi] == hit_col);
    end
  endgenerate

  assign tile_known = |match_vec;
  assign table_full = &valid_eff;
  assign counted    = raw_hit && (state_reg == PLAY) && !newGame && !tile_known && !table_full;

  always_comb begin
    free_idx = '0;
    for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
      if (!valid_eff[i]) free_idx = 2'(i);
    end
  end

  // Four-digit BCD add of a two-digit increment; a carry out of the top digit saturates.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] b_wide;
    logic [15:0] sum;
    logic [4:0]  digit;
    logic        carry;
    b_wide = {8'h00, b};
    sum    = '0;
    carry  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      digit = {1'b0, a[4*i +: 4]} + {1'b0, b_wide[4*i +: 4]} + {4'd0, carry};
      if (digit > 5'd9) begin
        digit = digit - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = digit[3:0];
    end
    return carry ? 16'h9999 : sum;
  endfunction

  always_comb begin
    state_next = state_reg;
    pulse_next = 1'b0;
    score_next = score_reg;
    coins_next = coins_reg;
    done_next  = done_reg;
    valid_next = valid_eff;
    if (newGame) begin
      state_next = PLAY;
      score_next = '0;
      coins_next = COINS_INIT;
      done_next  = 1'b0;
      valid_next = '0;
    end else if (counted) begin
      valid_next[free_idx] = 1'b1;
      pulse_next           = 1'b1;
      score_next           = bcd_add_sat(score_reg, COIN_POINTS_BCD);
      coins_next           = (coins_reg == 9'd0) ? 9'd0 : coins_reg - 9'd1;
      if (coins_reg == 9'd1) begin
        done_next  = 1'b1;
        state_next = CLEARED;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= IDLE;
      pulse_reg <= 1'b0;
      score_reg <= '0;
      coins_reg <= COINS_INIT;
      done_reg  <= 1'b0;
      valid_reg <= '0;
    end else begin
      state_reg <= state_next;
      pulse_reg <= pulse_next;
      score_reg <= score_next;
      coins_reg <= coins_next;
      done_reg  <= done_next;
      valid_reg <= valid_next;
    end
  end

  // Tile coordinates are only meaningful behind a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (counted) begin
      row_reg[free_idx] <= hit_row;
      col_reg[free_idx] <= hit_col;
    end
  end

  assign collision_pc = pulse_reg;
  assign score        = score_reg;
  assign coinsLeft    = coins_reg;
  assign levelDone    = done_reg;

endmodule
